// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: picks an unfinished warp, steps it through one
// instruction (FETCH..UPDATE), then yields to the next unfinished warp.
package warp_scheduler_pkg;
  typedef enum logic [2:0] {
    WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST, WARP_WAIT, WARP_EXECUTE, WARP_UPDATE
  } warp_state_t;
endpackage

// state    | meaning
// S_IDLE   | waiting for first start
// S_SELECT | one-cycle round-robin scan for an unfinished warp
// S_RUN    | active warp stepping through warp_state phases
// S_DONE   | every launched warp retired; waiting for start
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int WARP_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WARP_W:0]      num_warps_active,
  input  logic                 fetch_done,
  input  logic                 decoded_mem_access,
  input  logic                 decoded_ret,
  input  logic                 lsu_done,
  output logic [NUM_WARPS-1:0] warp_enable,
  output logic [WARP_W-1:0]    active_warp,
  output warp_state_t          warp_state,
  output logic [NUM_WARPS-1:0] warps_finished,
  output logic [31:0]          retired_count,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_RUN, S_DONE} top_t;

  top_t                 top;
  logic [WARP_W-1:0]    rr_ptr;
  logic [WARP_W-1:0]    sel_slot;
  logic [WARP_W-1:0]    scan_idx;
  logic                 sel_found;
  logic [NUM_WARPS-1:0] launch_mask;
  logic [NUM_WARPS-1:0] sel_onehot;
  int                   n_launch;

  // Scan starts just past the last warp that ran, so every warp gets a turn.
  always_comb begin
    sel_found  = 1'b0;
    sel_slot   = '0;
    scan_idx   = '0;
    sel_onehot = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      scan_idx = WARP_W'((int'(rr_ptr) + i) % NUM_WARPS);
      if (!sel_found && !warps_finished[scan_idx]) begin
        sel_found = 1'b1;
        sel_slot  = scan_idx;
      end
    end
    sel_onehot[sel_slot] = 1'b1;
  end

  always_comb begin
    launch_mask = '0;
    n_launch    = int'(num_warps_active);
    if (n_launch > NUM_WARPS) n_launch = NUM_WARPS;
    for (int i = 0; i < NUM_WARPS; i++) launch_mask[i] = (i < n_launch);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top            <= S_IDLE;
      warp_state     <= WARP_IDLE;
      warp_enable    <= '0;
      active_warp    <= '0;
      warps_finished <= '0;
      retired_count  <= '0;
      done           <= 1'b0;
      rr_ptr         <= WARP_W'(NUM_WARPS - 1);
    end else begin
      case (top)
        S_IDLE, S_DONE: begin
          if (start) begin
            top            <= S_SELECT;
            warps_finished <= ~launch_mask;
            retired_count  <= '0;
            done           <= 1'b0;
            rr_ptr         <= WARP_W'(NUM_WARPS - 1);
          end
        end
        S_SELECT: begin
          if (sel_found) begin
            top         <= S_RUN;
            active_warp <= sel_slot;
            rr_ptr      <= sel_slot;
            warp_enable <= sel_onehot;
            warp_state  <= WARP_FETCH;
          end else begin
            top  <= S_DONE;
            done <= 1'b1;
          end
        end
        S_RUN: begin
          case (warp_state)
            WARP_FETCH:   if (fetch_done) warp_state <= WARP_DECODE;
            WARP_DECODE:  warp_state <= WARP_REQUEST;
            WARP_REQUEST: warp_state <= decoded_mem_access ? WARP_WAIT : WARP_EXECUTE;
            WARP_WAIT:    if (lsu_done) warp_state <= WARP_UPDATE;
            WARP_EXECUTE: warp_state <= WARP_UPDATE;
            WARP_UPDATE: begin
              retired_count <= retired_count + 32'd1;
              if (decoded_ret) warps_finished[active_warp] <= 1'b1;
              top         <= S_SELECT;
              warp_state  <= WARP_IDLE;
              warp_enable <= '0;
            end
            default: begin
              top         <= S_SELECT;
              warp_state  <= WARP_IDLE;
              warp_enable <= '0;
            end
          endcase
        end
        default: top <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Bench for warp_scheduler: randomized/directed stimulus, per-cycle compare
// against a behavioural model, plus hand-computed scenario expectations.
module tb_warp_scheduler;
  import warp_scheduler_pkg::*;

  localparam int NW = 4;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [WW:0]   num_warps_active;
  logic          fetch_done, decoded_mem_access, decoded_ret, lsu_done;
  logic [NW-1:0] warp_enable, warps_finished;
  logic [WW-1:0] active_warp;
  warp_state_t   warp_state;
  logic [31:0]   retired_count;
  logic          done;

  warp_scheduler #(.NUM_WARPS(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_warps_active(num_warps_active),
    .fetch_done(fetch_done), .decoded_mem_access(decoded_mem_access),
    .decoded_ret(decoded_ret), .lsu_done(lsu_done), .warp_enable(warp_enable),
    .active_warp(active_warp), .warp_state(warp_state), .warps_finished(warps_finished),
    .retired_count(retired_count), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 choosing, 2 running, 3 all done
  int            m_mode;
  warp_state_t   m_ph;
  int            m_act, m_last;
  logic [NW-1:0] m_fin;
  logic [31:0]   m_ret;
  logic          m_done;
  int            m_cnt[NW];

  always @(posedge clk) begin
    int n, pick;
    if (reset) begin
      m_mode = 0; m_ph = WARP_IDLE; m_act = 0; m_fin = '0;
      m_ret = 0; m_done = 1'b0; m_last = NW - 1;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (start) begin
        n = (int'(num_warps_active) > NW) ? NW : int'(num_warps_active);
        m_fin = '1;
        for (int w = 0; w < n; w++) m_fin[w] = 1'b0;
        for (int w = 0; w < NW; w++) m_cnt[w] = 0;
        m_ret = 0; m_done = 1'b0; m_last = NW - 1; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      pick = -1;
      for (int k = 1; k <= NW && pick < 0; k++)
        if (!m_fin[(m_last + k) % NW]) pick = (m_last + k) % NW;
      if (pick >= 0) begin
        m_act = pick; m_last = pick; m_mode = 2; m_ph = WARP_FETCH;
      end else begin
        m_mode = 3; m_done = 1'b1;
      end
    end else begin
      unique case (m_ph)
        WARP_FETCH:   if (fetch_done) m_ph = WARP_DECODE;
        WARP_DECODE:  m_ph = WARP_REQUEST;
        WARP_REQUEST: m_ph = decoded_mem_access ? WARP_WAIT : WARP_EXECUTE;
        WARP_WAIT:    if (lsu_done) m_ph = WARP_UPDATE;
        WARP_EXECUTE: m_ph = WARP_UPDATE;
        default: begin
          m_ret = m_ret + 1;
          if (decoded_ret) m_fin[m_act] = 1'b1;
          m_cnt[m_act]++;
          m_mode = 1; m_ph = WARP_IDLE;
        end
      endcase
    end
  end

  logic check_en = 1'b0;
  always @(negedge clk) if (check_en) begin
    chk("warp_enable", warp_enable, (m_mode == 2) ? (64'(1) << m_act) : 64'd0);
    chk("active_warp", active_warp, m_act);
    chk("warp_state", warp_state, m_ph);
    chk("warps_finished", warps_finished, m_fin);
    chk("retired_count", retired_count, m_ret);
    chk("done", done, m_done);
  end

  // order in which the DUT starts instructions
  int ord[$];
  warp_state_t prev_ws = WARP_IDLE;
  always @(negedge clk) begin
    if (warp_state == WARP_FETCH && prev_ws != WARP_FETCH) ord.push_back(int'(active_warp));
    prev_ws = warp_state;
  end

  // ---------------- stimulus driver ----------------
  logic auto_drive = 1'b0;
  int p_fetch = 50, p_mem = 50, p_lsu = 50, p_ret = 50, ret_mode = 0;
  always @(negedge clk) if (auto_drive) begin
    fetch_done         = ($urandom_range(99) < p_fetch);
    decoded_mem_access = ($urandom_range(99) < p_mem);
    lsu_done           = ($urandom_range(99) < p_lsu);
    case (ret_mode)
      1: decoded_ret = 1'b1;
      2: decoded_ret = (m_act == 1 && m_cnt[1] == 0) || ((m_act == 0 || m_act == 2) && m_cnt[m_act] == 2);
      3: decoded_ret = 1'b0;
      default: decoded_ret = ($urandom_range(99) < p_ret);
    endcase
  end

  task automatic run_start(input int n, input int limit, output int cyc);
    num_warps_active = 3'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", done, 1'b1);
  endtask

  initial begin
    int cyc, seen, guard;
    int exp_ord[7] = '{0, 1, 2, 0, 2, 0, 2};
    warp_state_t exp_ws[14];
    exp_ws = '{WARP_IDLE, WARP_IDLE, WARP_FETCH, WARP_FETCH, WARP_FETCH, WARP_FETCH, WARP_DECODE,
               WARP_REQUEST, WARP_WAIT, WARP_WAIT, WARP_WAIT, WARP_UPDATE, WARP_IDLE, WARP_IDLE};

    // T1: reset with random inputs
    reset = 1'b1; start = 1'b0; num_warps_active = '0;
    fetch_done = 0; decoded_mem_access = 0; decoded_ret = 0; lsu_done = 0;
    auto_drive = 1'b1;
    repeat (2) begin
      @(negedge clk);
      start = 1'($urandom_range(1));
      num_warps_active = 3'($urandom_range(7));
    end
    @(negedge clk);
    check_en = 1'b1;
    chk("t1_enable", warp_enable, 0);
    chk("t1_done", done, 0);
    chk("t1_retired", retired_count, 0);
    chk("t1_state", warp_state, WARP_IDLE);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    // T2: single warp, straight-line retiring instruction
    p_fetch = 100; p_mem = 0; ret_mode = 1;
    run_start(1, 50, cyc);
    chk("t2_latency", cyc, 8);
    chk("t2_retired", retired_count, 1);
    chk("t2_finished", warps_finished, 4'b1111);

    // T3: three warps, warp1 retires first, warps 0/2 on their third instruction
    p_mem = 30; p_lsu = 60; ret_mode = 2;
    ord.delete();
    run_start(3, 400, cyc);
    chk("t3_retired", retired_count, 7);
    chk("t3_finished", warps_finished, 4'b1111);
    chk("t3_order_len", ord.size(), 7);
    for (int i = 0; i < 7 && i < ord.size(); i++) chk($sformatf("t3_order%0d", i), ord[i], exp_ord[i]);

    // T4: delayed fetch, memory instruction with stray lsu_done during FETCH
    auto_drive = 1'b0;
    num_warps_active = 3'd1;
    fetch_done = 0; lsu_done = 0; decoded_mem_access = 1; decoded_ret = 1;
    start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      start = 1'b0;
      fetch_done = (k >= 5);
      lsu_done = (k == 2 || k == 3 || k >= 10);
      chk($sformatf("t4_state%0d", k), warp_state, exp_ws[k]);
      if (k >= 2 && k <= 11) chk($sformatf("t4_enable%0d", k), warp_enable, 4'b0001);
    end
    chk("t4_done", done, 1'b1);
    chk("t4_retired", retired_count, 1);

    // T5a: zero warps launched
    auto_drive = 1'b1; p_fetch = 60; p_mem = 40; p_lsu = 50; p_ret = 40; ret_mode = 0;
    run_start(0, 20, cyc);
    chk("t5_zero_latency", cyc, 2);
    chk("t5_zero_finished", warps_finished, 4'b1111);
    chk("t5_zero_retired", retired_count, 0);

    // T5b: oversubscribed count clamps to 4; start during S_RUN ignored
    ord.delete();
    num_warps_active = 3'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (warp_state != WARP_FETCH && guard < 20) begin @(negedge clk); guard++; end
    chk("t5_reached_run", warp_state, WARP_FETCH);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 3000) begin @(negedge clk); guard++; end
    chk("t5_done", done, 1'b1);
    seen = 0;
    foreach (ord[i]) seen |= (1 << ord[i]);
    chk("t5_warps_seen", seen, 4'hF);
    chk("t5_finished", warps_finished, 4'hF);

    // T6: reset while waiting on the LSU, then a clean relaunch
    p_mem = 100; p_lsu = 25; ret_mode = 3;
    num_warps_active = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(retired_count >= 2 && warp_state == WARP_WAIT) && guard < 500) begin @(negedge clk); guard++; end
    chk("t6_reached_wait", warp_state, WARP_WAIT);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_enable", warp_enable, 0);
    chk("t6_retired", retired_count, 0);
    chk("t6_state", warp_state, WARP_IDLE);
    chk("t6_done", done, 0);
    reset = 1'b0;
    p_mem = 50; p_lsu = 50; p_ret = 50; ret_mode = 0;
    run_start(2, 2000, cyc);
    chk("t6_finished", warps_finished, 4'hF);

    // randomized launches
    repeat (8) begin
      p_fetch = $urandom_range(100, 20);
      p_mem   = $urandom_range(100);
      p_lsu   = $urandom_range(100, 20);
      p_ret   = $urandom_range(70, 20);
      run_start($urandom_range(7), 3000, cyc);
      chk("rand_finished", warps_finished, 4'hF);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
